term_stream_arbiter: RTL



---
 rtl/term_stream_arbiter_if.sv | 25 ++
 rtl/term_stream_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/term_stream_arbiter_if.sv
// Byte-stream bundle between the two requesters, the arbiter and the ANSI parser input.
// The master modport is the requester/parser side; the slave modport is the arbiter.
interface term_stream_arbiter_if;
  logic       req0Valid;
  logic [7:0] req0Data;
  logic       req0Ready;
  logic       req1Valid;
  logic [7:0] req1Data;
  logic       req1Ready;
  logic       outValid;
  logic [7:0] outData;
  logic       lockActive;
  logic       lockOwner;
  logic       lockTimeout;

  modport master (
    output req0Valid, req0Data, req1Valid, req1Data,
    input  req0Ready, req1Ready, outValid, outData, lockActive, lockOwner, lockTimeout
  );

  modport slave (
    input  req0Valid, req0Data, req1Valid, req1Data,
    output req0Ready, req1Ready, outValid, outData, lockActive, lockOwner, lockTimeout
  );
endinterface

// File: rtl/term_stream_arbiter.sv
// Round-robin byte arbiter feeding the ANSI parser; locks onto a requester for a whole escape sequence.
// Optional lock watchdog compiled in with `define STREAM_ARB_TIMEOUT_EN.
module term_stream_arbiter #(
  parameter int MIN_GAP = 0,
  parameter int MAX_SEQ = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  resetn,
  term_stream_arbiter_if.slave  bus
);

  localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam int SEQ_W = $clog2(MAX_SEQ + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(MIN_GAP);
  localparam logic [SEQ_W-1:0] SEQ_LIMIT = SEQ_W'(MAX_SEQ);

  typedef enum logic [1:0] {
    IDLE,
    ESC,
    CSI
  } state_t;

  state_t           state;
  state_t           nextState;
  logic [GAP_W-1:0] gapCnt;
  logic [SEQ_W-1:0] seqCnt;
  logic [SEQ_W-1:0] nextSeq;
  logic [SEQ_W-1:0] seqInc;
  logic             lastGrant;
  logic             lockOwnerQ;
  logic             lockActiveQ;
  logic             outValidQ;
  logic [7:0]       outDataQ;
  logic             canIssue;
  logic             sel;
  logic             xfer;
  logic [7:0]       selData;

  assign canIssue = (gapCnt == '0);

  // While locked only the owner may be served; otherwise round-robin on ties.
  always_comb begin
    sel = 1'b0;
    if (lockActiveQ) begin
      sel = lockOwnerQ;
    end else if (bus.req0Valid && bus.req1Valid) begin
      sel = ~lastGrant;
    end else if (bus.req1Valid) begin
      sel = 1'b1;
    end
  end

  assign bus.req0Ready = canIssue & ~sel & bus.req0Valid;
  assign bus.req1Ready = canIssue &  sel & bus.req1Valid;
  assign xfer          = bus.req0Ready | bus.req1Ready;
  assign selData       = sel ? bus.req1Data : bus.req0Data;
  assign seqInc        = seqCnt + 1'b1;

  // Escape-sequence tracker, evaluated against the byte being transferred this cycle.
  always_comb begin
    nextState = state;
    nextSeq   = seqCnt;
    unique case (state)
      IDLE: begin
        if (selData == 8'h1B) begin
          nextState = ESC;
        end
      end
      ESC: begin
        nextSeq = seqInc;
        if (selData == 8'h5B) begin
          nextState = CSI;
        end else begin
          nextState = IDLE;
        end
      end
      CSI: begin
        nextSeq = seqInc;
        if (selData >= 8'h30 && selData <= 8'h3F) begin
          nextState = CSI;
        end else begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
    if (state != IDLE && seqInc >= SEQ_LIMIT) begin
      nextState = IDLE;
    end
    if (nextState == IDLE) begin
      nextSeq = '0;
    end
  end

`ifdef STREAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] toCnt;
  logic            lockTimeoutQ;
  logic            ownerValid;
  logic            timeoutHit;

  assign ownerValid      = lockOwnerQ ? bus.req1Valid : bus.req0Valid;
  assign timeoutHit      = lockActiveQ & ~ownerValid & (toCnt == TO_LAST);
  assign bus.lockTimeout = lockTimeoutQ;
`else
  // Watchdog compiled out: TIMEOUT is never negative, so this pulse is constant 0.
  assign bus.lockTimeout = (TIMEOUT < 0);
`endif

  // Single registered FSM: grant bookkeeping, output strobe, throttle gap and lock state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      gapCnt      <= '0;
      seqCnt      <= '0;
      lastGrant   <= 1'b1;
      lockOwnerQ  <= 1'b0;
      lockActiveQ <= 1'b0;
      outValidQ   <= 1'b0;
      outDataQ    <= 8'h00;
`ifdef STREAM_ARB_TIMEOUT_EN
      toCnt        <= '0;
      lockTimeoutQ <= 1'b0;
`endif
    end else begin
      outValidQ <= xfer;
`ifdef STREAM_ARB_TIMEOUT_EN
      lockTimeoutQ <= 1'b0;
`endif
      if (xfer) begin
        outDataQ    <= selData;
        lastGrant   <= sel;
        lockOwnerQ  <= sel;
        state       <= nextState;
        seqCnt      <= nextSeq;
        lockActiveQ <= (nextState != IDLE);
        gapCnt      <= GAP_LOAD;
`ifdef STREAM_ARB_TIMEOUT_EN
        toCnt       <= '0;
`endif
      end else begin
        if (!canIssue) begin
          gapCnt <= gapCnt - 1'b1;
        end
`ifdef STREAM_ARB_TIMEOUT_EN
        // A silent owner must not starve the other source forever.
        if (timeoutHit) begin
          state        <= IDLE;
          seqCnt       <= '0;
          lockActiveQ  <= 1'b0;
          lockTimeoutQ <= 1'b1;
          toCnt        <= '0;
        end else if (lockActiveQ && !ownerValid) begin
          toCnt <= toCnt + 1'b1;
        end else if (!lockActiveQ) begin
          toCnt <= '0;
        end
`endif
      end
    end
  end

  assign bus.outValid   = outValidQ;
  assign bus.outData    = outDataQ;
  assign bus.lockActive = lockActiveQ;
  assign bus.lockOwner  = lockOwnerQ;

endmodule
